divide_sequencer: RTL and testbench

Multi-cycle integer divider controller for the ALU. It sequences one shared `Subtractor` instance through a restoring shift/subtract loop, one quotient bit per clock, and produces the quotient, the remainder and a divide-by-zero flag. It sits beside the combinational ALU units and is launched by the ALU control logic through a start/busy/done handshake.

---
 rtl/divide_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_divide_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/divide_sequencer.sv
// -----------------------------------------------------------------------------
// divide_sequencer
//
// Multi-cycle restoring integer divider controller for the ALU. One shared
// Subtractor is stepped through a shift/subtract loop that produces one
// quotient bit per clock, MSB of the dividend first.
//
// Width comes from the `WIDTH macro (normally provided by ALU_inc.v). It
// defaults to 8 here so that the file also stands on its own.
//
// Optional feature macro: DIV_SIGNED_EN
//   defined   : signedOp=1 selects a signed divide (truncating toward zero).
//               Operands are converted to magnitudes at capture. An extra
//               FIX state re-applies the signs.
//   undefined : signedOp is ignored and every divide is unsigned.
//
// Ports
//   clk        in   clock, rising edge
//   rstN       in   synchronous active-low reset
//   start      in   launch request, sampled only in IDLE
//   signedOp   in   signed divide select (used only with DIV_SIGNED_EN)
//   dividend   in   [WIDTH] captured on an accepted start
//   divisor    in   [WIDTH] captured on an accepted start
//   quotient   out  [WIDTH] result register
//   remainder  out  [WIDTH] result register
//   busy       out  high from the cycle after an accepted start until done
//   done       out  one-cycle pulse when the results become valid
//   divZero    out  set with done when the divisor was 0, cleared on next start
//
// Handshake: start is honoured only while the FSM is in IDLE. Any start seen
// in RUN, FIX or DONE is dropped, not queued. busy and done are never high
// together. done lasts exactly one cycle, and the result registers hold their
// values after it.
// -----------------------------------------------------------------------------
`ifndef WIDTH
`define WIDTH 8
`endif

// Shared subtractor: result = a + ~b + 1. statusOut = {borrow, zero}.
module Subtractor (
  input  logic [`WIDTH-1:0] a,
  input  logic [`WIDTH-1:0] b,
  output logic [`WIDTH-1:0] result,
  output logic [1:0]        statusOut
);
  logic [`WIDTH:0] sum;

  assign sum       = {1'b0, a} + {1'b0, ~b} + {{`WIDTH{1'b0}}, 1'b1};
  assign result    = sum[`WIDTH-1:0];
  assign statusOut = {~sum[`WIDTH], (sum[`WIDTH-1:0] == '0)};
endmodule

module divide_sequencer (
  input  logic              clk,
  input  logic              rstN,
  input  logic              start,
  input  logic              signedOp,
  input  logic [`WIDTH-1:0] dividend,
  input  logic [`WIDTH-1:0] divisor,
  output logic [`WIDTH-1:0] quotient,
  output logic [`WIDTH-1:0] remainder,
  output logic              busy,
  output logic              done,
  output logic              divZero
);
  localparam int W  = `WIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
`ifdef DIV_SIGNED_EN
    FIX  = 2'd2,
`endif
    DONE = 2'd3
  } state_t;

  state_t        state, next_state;
  logic [W-1:0]  dvd_q;      // dividend, shifted left as its bits are consumed
  logic [W-1:0]  dvs_q;      // divisor (magnitude in signed mode)
  logic [W-1:0]  rem_q;      // partial remainder; bit WIDTH is always 0 between steps
  logic [W-1:0]  quo_q;      // quotient shift register
  logic [CW-1:0] cnt_q;
  logic          last_iter;
  logic          go_fix;

  // One iteration: R (WIDTH+1 bits) after shifting in the next dividend bit.
  logic [W:0]    shifted;
  logic          take;
  logic [W-1:0]  sub_result;
  logic [1:0]    sub_status_unused;
  logic [W:0]    rem_next;
  logic [W-1:0]  quo_next;
  logic [W-1:0]  dvd_in;
  logic [W-1:0]  dvs_in;

  assign shifted   = {rem_q, dvd_q[W-1]};
  assign take      = shifted[W] | ({1'b0, shifted[W-1:0]} >= {1'b0, dvs_q});
  // When take is set, the true difference is below the divisor. So the
  // WIDTH-bit subtraction is exact even when shifted[W] was set.
  assign rem_next  = take ? {1'b0, sub_result} : shifted;
  assign quo_next  = {quo_q[W-2:0], take};
  assign last_iter = (cnt_q == CW'(W - 1));

  Subtractor u_sub (
    .a         (shifted[W-1:0]),
    .b         (dvs_q),
    .result    (sub_result),
    .statusOut (sub_status_unused)
  );

`ifdef DIV_SIGNED_EN
  logic sgn_q, qneg_q, rneg_q;
  assign go_fix = sgn_q;
  // Two's-complement magnitudes, (~x)+1, taken only for negative operands.
  assign dvd_in = (signedOp & dividend[W-1]) ? (~dividend) + W'(1) : dividend;
  assign dvs_in = (signedOp & divisor[W-1])  ? (~divisor)  + W'(1) : divisor;
`else
  logic signed_op_unused;
  assign signed_op_unused = signedOp;
  assign go_fix = 1'b0;
  assign dvd_in = dividend;
  assign dvs_in = divisor;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rstN) state <= IDLE;
    else       state <= next_state;
  end

  // Next state and handshake outputs
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = (divisor == '0) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_iter) begin
`ifdef DIV_SIGNED_EN
          next_state = go_fix ? FIX : DONE;
`else
          next_state = DONE;
`endif
        end
      end
`ifdef DIV_SIGNED_EN
      FIX: begin
        busy       = 1'b1;
        next_state = DONE;
      end
`endif
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (!rstN) begin
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      quotient  <= '0;
      remainder <= '0;
      divZero   <= 1'b0;
`ifdef DIV_SIGNED_EN
      sgn_q     <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            divZero <= 1'b0;
            if (divisor == '0) begin
              // The raw dividend is reported even for a signed divide.
              quotient  <= '1;
              remainder <= dividend;
              divZero   <= 1'b1;
            end else begin
              dvd_q <= dvd_in;
              dvs_q <= dvs_in;
              rem_q <= '0;
              quo_q <= '0;
              cnt_q <= '0;
`ifdef DIV_SIGNED_EN
              sgn_q  <= signedOp;
              qneg_q <= signedOp & (dividend[W-1] ^ divisor[W-1]);
              rneg_q <= signedOp & dividend[W-1];
`endif
            end
          end
        end
        RUN: begin
          dvd_q <= {dvd_q[W-2:0], 1'b0};
          rem_q <= rem_next[W-1:0];
          quo_q <= quo_next;
          cnt_q <= cnt_q + CW'(1);
          // Unsigned results load on the final step, so they appear with done.
          if (last_iter && !go_fix) begin
            quotient  <= quo_next;
            remainder <= rem_next[W-1:0];
          end
        end
`ifdef DIV_SIGNED_EN
        FIX: begin
          quotient  <= qneg_q ? (~quo_q) + W'(1) : quo_q;
          remainder <= rneg_q ? (~rem_q) + W'(1) : rem_q;
        end
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_divide_sequencer.sv
// -----------------------------------------------------------------------------
// tb_divide_sequencer: directed test bench for divide_sequencer (WIDTH=8).
// Each scenario task drives stimulus and compares against hand-computed values.
// -----------------------------------------------------------------------------
`ifndef WIDTH
`define WIDTH 8
`endif

module tb_divide_sequencer;
  logic              clk = 1'b0;
  logic              rstN;
  logic              start;
  logic              signedOp;
  logic [`WIDTH-1:0] dividend;
  logic [`WIDTH-1:0] divisor;
  logic [`WIDTH-1:0] quotient;
  logic [`WIDTH-1:0] remainder;
  logic              busy;
  logic              done;
  logic              divZero;

  int checks = 0;
  int errors = 0;

  divide_sequencer dut (
    .clk       (clk),
    .rstN      (rstN),
    .start     (start),
    .signedOp  (signedOp),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .divZero   (divZero)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Move to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: present a start for one edge. On return we are in cycle t+1.
  task automatic launch(input logic [`WIDTH-1:0] dd, input logic [`WIDTH-1:0] ds,
                        input logic sg);
    dividend = dd;
    divisor  = ds;
    signedOp = sg;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Bounded wait for done. lat counts cycles from t+1 (lat=1) up to the done
  // cycle. bc counts how many of the cycles before done had busy high.
  task automatic wait_done(output int lat, output int bc);
    lat = 1;
    bc  = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bc++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rstN = 1'b0; start = 1'b0; signedOp = 1'b0; dividend = '0; divisor = '0;
    tick(); tick();
    checks++; if (quotient !== 8'h00)  begin errors++; $display("FAIL reset_q got %h want 00", quotient); end
    checks++; if (remainder !== 8'h00) begin errors++; $display("FAIL reset_r got %h want 00", remainder); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0)       begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (divZero !== 1'b0)    begin errors++; $display("FAIL reset_dz got %b want 0", divZero); end
    rstN = 1'b1;
    tick();
  endtask

  task automatic test_unsigned();
    int lat, bc;
    launch(8'd100, 8'd7, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL u_busy_t1 got %b want 1", busy); end
    wait_done(lat, bc);
    checks++; if (lat != 9)  begin errors++; $display("FAIL u_latency got %0d want 9", lat); end
    checks++; if (bc != 8)   begin errors++; $display("FAIL u_busy_cycles got %0d want 8", bc); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL u_busy_at_done got %b want 0", busy); end
    checks++; if (quotient !== 8'd14)  begin errors++; $display("FAIL u_q got %0d want 14", quotient); end
    checks++; if (remainder !== 8'd2)  begin errors++; $display("FAIL u_r got %0d want 2", remainder); end
    checks++; if (divZero !== 1'b0)    begin errors++; $display("FAIL u_dz got %b want 0", divZero); end
    tick();
    checks++; if (done !== 1'b0)       begin errors++; $display("FAIL u_done_pulse got %b want 0", done); end
    checks++; if (quotient !== 8'd14)  begin errors++; $display("FAIL u_q_hold got %0d want 14", quotient); end
  endtask

  task automatic test_edges();
    logic [7:0] tdd [3] = '{8'd255, 8'd200, 8'd255};
    logic [7:0] tds [3] = '{8'd1,   8'd201, 8'd129};
    logic [7:0] tq  [3] = '{8'd255, 8'd0,   8'd1};
    logic [7:0] tr  [3] = '{8'd0,   8'd200, 8'd126};
    int lat, bc;
    for (int i = 0; i < 3; i++) begin
      launch(tdd[i], tds[i], 1'b0);
      wait_done(lat, bc);
      checks++; if (lat != 9) begin errors++; $display("FAIL edge%0d_latency got %0d want 9", i, lat); end
      checks++; if (quotient !== tq[i])  begin errors++; $display("FAIL edge%0d_q got %0d want %0d", i, quotient, tq[i]); end
      checks++; if (remainder !== tr[i]) begin errors++; $display("FAIL edge%0d_r got %0d want %0d", i, remainder, tr[i]); end
      tick();
    end
  endtask

  task automatic test_div_zero();
    int lat, bc;
    launch(8'd5, 8'd0, 1'b0);
    wait_done(lat, bc);
    checks++; if (lat != 1) begin errors++; $display("FAIL dz_latency got %0d want 1", lat); end
    checks++; if (bc != 0)  begin errors++; $display("FAIL dz_busy got %0d want 0", bc); end
    checks++; if (quotient !== 8'hFF) begin errors++; $display("FAIL dz_q got %h want ff", quotient); end
    checks++; if (remainder !== 8'd5) begin errors++; $display("FAIL dz_r got %0d want 5", remainder); end
    checks++; if (divZero !== 1'b1)   begin errors++; $display("FAIL dz_flag got %b want 1", divZero); end
    tick();
    checks++; if (divZero !== 1'b1)   begin errors++; $display("FAIL dz_flag_hold got %b want 1", divZero); end
    launch(8'd9, 8'd3, 1'b0);
    checks++; if (divZero !== 1'b0)   begin errors++; $display("FAIL dz_clear got %b want 0", divZero); end
    wait_done(lat, bc);
    checks++; if (quotient !== 8'd3)  begin errors++; $display("FAIL dz_next_q got %0d want 3", quotient); end
    checks++; if (remainder !== 8'd0) begin errors++; $display("FAIL dz_next_r got %0d want 0", remainder); end
    tick();
  endtask

  task automatic test_start_busy();
    int lat, bc;
    launch(8'd100, 8'd7, 1'b0);  // now in cycle t+1
    tick(); tick();               // cycle t+3
    dividend = 8'd50; divisor = 8'd3; start = 1'b1;
    tick();                       // cycle t+4
    start = 1'b0;
    wait_done(lat, bc);
    checks++; if (lat + 3 != 9) begin errors++; $display("FAIL sb_latency got %0d want 9", lat + 3); end
    checks++; if (quotient !== 8'd14) begin errors++; $display("FAIL sb_q got %0d want 14", quotient); end
    checks++; if (remainder !== 8'd2) begin errors++; $display("FAIL sb_r got %0d want 2", remainder); end
    tick();
    launch(8'd50, 8'd5, 1'b0);
    wait_done(lat, bc);
    checks++; if (lat != 9) begin errors++; $display("FAIL sb_next_latency got %0d want 9", lat); end
    checks++; if (quotient !== 8'd10) begin errors++; $display("FAIL sb_next_q got %0d want 10", quotient); end
    checks++; if (remainder !== 8'd0) begin errors++; $display("FAIL sb_next_r got %0d want 0", remainder); end
    tick();
  endtask

  task automatic test_reset_mid();
    int lat, bc, pulses;
    launch(8'd100, 8'd7, 1'b0);  // cycle t+1
    tick(); tick(); tick();       // cycle t+4
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    checks++; if (quotient !== 8'h00)  begin errors++; $display("FAIL rm_q got %h want 00", quotient); end
    checks++; if (remainder !== 8'h00) begin errors++; $display("FAIL rm_r got %h want 00", remainder); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rm_busy got %b want 0", busy); end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) pulses++;
      tick();
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL rm_no_done got %0d want 0", pulses); end
    launch(8'd100, 8'd7, 1'b0);
    wait_done(lat, bc);
    checks++; if (lat != 9) begin errors++; $display("FAIL rm_latency got %0d want 9", lat); end
    checks++; if (quotient !== 8'd14) begin errors++; $display("FAIL rm_q2 got %0d want 14", quotient); end
    checks++; if (remainder !== 8'd2) begin errors++; $display("FAIL rm_r2 got %0d want 2", remainder); end
    tick();
  endtask

`ifdef DIV_SIGNED_EN
  task automatic test_signed();
    logic [7:0] tdd [3] = '{8'h9C, 8'd100, 8'h80};
    logic [7:0] tds [3] = '{8'd7,  8'hF9,  8'hFF};
    logic [7:0] tq  [3] = '{8'hF2, 8'hF2,  8'h80};
    logic [7:0] tr  [3] = '{8'hFE, 8'h02,  8'h00};
    int lat, bc;
    for (int i = 0; i < 3; i++) begin
      launch(tdd[i], tds[i], 1'b1);
      wait_done(lat, bc);
      checks++; if (lat != 10) begin errors++; $display("FAIL s%0d_latency got %0d want 10", i, lat); end
      checks++; if (bc != 9)   begin errors++; $display("FAIL s%0d_busy got %0d want 9", i, bc); end
      checks++; if (quotient !== tq[i])  begin errors++; $display("FAIL s%0d_q got %h want %h", i, quotient, tq[i]); end
      checks++; if (remainder !== tr[i]) begin errors++; $display("FAIL s%0d_r got %h want %h", i, remainder, tr[i]); end
      tick();
    end
  endtask
`else
  // Without signed support, signedOp=1 is ignored: 156/7 = 22 r 2.
  task automatic test_signed();
    int lat, bc;
    launch(8'h9C, 8'd7, 1'b1);
    wait_done(lat, bc);
    checks++; if (lat != 9) begin errors++; $display("FAIL ns_latency got %0d want 9", lat); end
    checks++; if (quotient !== 8'd22) begin errors++; $display("FAIL ns_q got %0d want 22", quotient); end
    checks++; if (remainder !== 8'd2) begin errors++; $display("FAIL ns_r got %0d want 2", remainder); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_unsigned();
    test_edges();
    test_div_zero();
    test_start_busy();
    test_reset_mid();
    test_signed();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
